// File: rtl/usb_hid_key_sequencer.sv
// -----------------------------------------------------------------------------
// usb_hid_key_sequencer
//
// Generates the key-press stream for the HID keyboard core. The HID core is
// driven through a key_value / key_request pulse interface.
//
// Key sources:
//   * A periodic auto-key generator. It steps through KEY_FIRST..KEY_LAST in
//     hold, up, down or ping-pong order.
//   * A FIFO of externally injected keys. The FIFO always has priority over
//     auto keys. A pending auto key is held back until the FIFO is empty.
//
// After every request the sequencer stays idle for at least GAP_CYCLES
// cycles, so the HID core is never over-driven.
//
// Optional feature (macro HID_KEY_RELEASE_EN):
//   When defined, every press request is followed by a release request
//   (key_value = 16'h0000). The release request comes after the first gap
//   and is followed by a second gap.
//   When undefined, one request is issued per key.
//
// Parameters:
//   CLK_HZ      clock frequency in Hz
//   PERIOD_MS   auto-key period in ms (PERIOD_CYC = CLK_HZ/1000*PERIOD_MS)
//   KEY_FIRST   lowest auto key code
//   KEY_LAST    highest auto key code (>= KEY_FIRST)
//   FIFO_DEPTH  injected-key FIFO depth (power of 2, >= 2)
//   GAP_CYCLES  minimum idle cycles after each request (>= 1)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   auto_en      enables periodic auto keys
//   mode         0 = hold, 1 = up, 2 = down, 3 = ping-pong
//   in_valid     injected key valid
//   in_key       injected key code
//   in_ready     FIFO can accept (equals !full)
//   fifo_count   FIFO occupancy
//   key_value    key code to the HID core
//   key_request  one-cycle request pulse to the HID core
//   busy         high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module usb_hid_key_sequencer #(
  parameter int unsigned CLK_HZ     = 60000000,
  parameter int unsigned PERIOD_MS  = 2000,
  parameter logic [15:0] KEY_FIRST  = 16'h0004,
  parameter logic [15:0] KEY_LAST   = 16'h0027,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP_CYCLES = 600000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          auto_en,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  input  logic [15:0]                   in_key,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   key_value,
  output logic                          key_request,
  output logic                          busy
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned PERIOD_CYC = CLK_HZ / 1000 * PERIOD_MS;
  localparam int          PCNT_W     = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int          GCNT_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam int          CW         = AW + 1;

  localparam logic [PCNT_W-1:0] PERIOD_LAST = PCNT_W'(PERIOD_CYC - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST    = GCNT_W'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]     FIFO_FULL   = CW'(FIFO_DEPTH);

`ifdef HID_KEY_RELEASE_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_RELEASE,
    ST_GAP_REL
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_t;
`endif

  state_t              state_reg;
  logic [GCNT_W-1:0]   gap_cnt_reg;
  logic                from_auto_reg;   // key in flight came from the auto generator

  logic [PCNT_W-1:0]   period_cnt_reg;
  logic                auto_pending_reg;
  logic [15:0]         auto_key_reg;
  logic                dir_down_reg;    // ping-pong direction, 0 = up

  logic [15:0]         auto_key_next;
  logic                dir_down_next;

  // ---------------------------------------------------------------------------
  // Injected-key FIFO
  // The storage array has no reset, so it can map onto distributed RAM.
  // ---------------------------------------------------------------------------
  logic [15:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                auto_take;

  assign fifo_full  = (count_reg == FIFO_FULL);
  assign fifo_empty = (count_reg == '0);
  assign in_ready   = !fifo_full;
  assign fifo_count = count_reg;

  // A push is gated by the pre-pop full flag. A full FIFO therefore refuses a
  // key even in a cycle where the FSM pops one.
  assign fifo_push  = in_valid && !fifo_full;
  assign fifo_pop   = (state_reg == ST_IDLE) && !fifo_empty;

  // The auto key is only taken when the FIFO has nothing to offer.
  assign auto_take  = (state_reg == ST_IDLE) && fifo_empty &&
                      auto_pending_reg && (mode != 2'd0);

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= in_key;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter and pending auto key
  // A tick that lands while a key is already pending is absorbed into it. A
  // tick in the same cycle as the FSM consuming the pending key re-arms it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_reg   <= '0;
      auto_pending_reg <= 1'b0;
    end else if (!auto_en) begin
      period_cnt_reg   <= '0;
      auto_pending_reg <= 1'b0;
    end else if (period_cnt_reg == PERIOD_LAST) begin
      period_cnt_reg   <= '0;
      auto_pending_reg <= 1'b1;
    end else begin
      period_cnt_reg <= period_cnt_reg + PCNT_W'(1);
      if (auto_take) begin
        auto_pending_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next auto key
  // The mode is sampled at the moment of the advance. A mode change never
  // reloads auto_key; it only changes how the next step is taken.
  // In ping-pong mode the endpoint flips direction and steps away in the same
  // advance, so the endpoint key is not repeated.
  // ---------------------------------------------------------------------------
  always_comb begin
    auto_key_next = auto_key_reg;
    dir_down_next = dir_down_reg;
    if (KEY_FIRST != KEY_LAST) begin
      case (mode)
        2'd1: begin
          auto_key_next = (auto_key_reg == KEY_LAST) ? KEY_FIRST
                                                     : auto_key_reg + 16'd1;
        end
        2'd2: begin
          auto_key_next = (auto_key_reg == KEY_FIRST) ? KEY_LAST
                                                      : auto_key_reg - 16'd1;
        end
        2'd3: begin
          if (!dir_down_reg) begin
            if (auto_key_reg == KEY_LAST) begin
              auto_key_next = auto_key_reg - 16'd1;
              dir_down_next = 1'b1;
            end else begin
              auto_key_next = auto_key_reg + 16'd1;
            end
          end else begin
            if (auto_key_reg == KEY_FIRST) begin
              auto_key_next = auto_key_reg + 16'd1;
              dir_down_next = 1'b0;
            end else begin
              auto_key_next = auto_key_reg - 16'd1;
            end
          end
        end
        default: begin
          auto_key_next = auto_key_reg;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // key_request is registered. It is set on the edge that enters ISSUE (or
  // RELEASE), so it is high for exactly the cycle spent in that state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      gap_cnt_reg   <= '0;
      from_auto_reg <= 1'b0;
      auto_key_reg  <= KEY_FIRST;
      dir_down_reg  <= 1'b0;
      key_value     <= KEY_FIRST;
      key_request   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      key_request <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fifo_pop) begin
            key_value     <= fifo_mem[rd_ptr_reg];
            from_auto_reg <= 1'b0;
            key_request   <= 1'b1;
            busy          <= 1'b1;
            state_reg     <= ST_ISSUE;
          end else if (auto_take) begin
            key_value     <= auto_key_reg;
            from_auto_reg <= 1'b1;
            key_request   <= 1'b1;
            busy          <= 1'b1;
            state_reg     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (from_auto_reg) begin
            auto_key_reg <= auto_key_next;
            dir_down_reg <= dir_down_next;
          end
          gap_cnt_reg <= '0;
          state_reg   <= ST_GAP;
        end

        ST_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
`ifdef HID_KEY_RELEASE_EN
            key_value   <= 16'h0000;
            key_request <= 1'b1;
            state_reg   <= ST_RELEASE;
`else
            busy        <= 1'b0;
            state_reg   <= ST_IDLE;
`endif
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GCNT_W'(1);
          end
        end

`ifdef HID_KEY_RELEASE_EN
        ST_RELEASE: begin
          gap_cnt_reg <= '0;
          state_reg   <= ST_GAP_REL;
        end

        ST_GAP_REL: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            busy        <= 1'b0;
            state_reg   <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GCNT_W'(1);
          end
        end
`endif

        default: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/usb_hid_key_sequencer.md
Name: usb_hid_key_sequencer

Overview:
- Generates the key-press stream for the HID keyboard core (key_value / key_request pulse interface).
- Parametrised successor to the fixed 2 s a..9 key counter: configurable period, key range and step mode (up/down/ping-pong).
- Adds a FIFO of externally injected keys that takes priority over auto-generated keys.
- Enforces a minimum gap between requests so the HID core is never over-driven.

Parameters:
- CLK_HZ, 60000000, clock frequency in Hz
- PERIOD_MS, 2000, auto-key period in ms; PERIOD_CYC = CLK_HZ/1000*PERIOD_MS, must be >= 1
- KEY_FIRST, 16'h0004, lowest auto key code
- KEY_LAST, 16'h0027, highest auto key code; KEY_LAST >= KEY_FIRST
- FIFO_DEPTH, 8, injected-key FIFO depth, power of 2, >= 2
- GAP_CYCLES, 600000, minimum idle cycles after each request, >= 1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- auto_en  in  1  enables periodic auto keys
- mode  in  2  0 = hold, 1 = up, 2 = down, 3 = ping-pong
- in_valid  in  1  injected key valid
- in_key  in  16  injected key code
- in_ready  out  1  FIFO can accept; equals !full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- key_value  out  16  key code to the HID core
- key_request  out  1  one-cycle request pulse to the HID core
- busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset values (async): key_value = KEY_FIRST, key_request = 0, busy = 0, in_ready = 1, fifo_count = 0. Internally: period counter = 0, auto_pending = 0, auto_key = KEY_FIRST, direction = up, FSM = IDLE.
- Period counter:
  - Counts 0..PERIOD_CYC-1 while auto_en = 1.
  - At the terminal count it wraps to 0 and sets auto_pending. A tick while auto_pending is already set is coalesced, not queued.
  - auto_en = 0 clears the counter and auto_pending synchronously.
- FIFO:
  - Push when in_valid & in_ready.
  - A push while full is not accepted, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves fifo_count unchanged.
- FSM, three states:
  - IDLE: if the FIFO is non-empty, pop the head into key_value and go to ISSUE. Otherwise, if auto_pending & mode != 0, load auto_key into key_value, clear auto_pending and go to ISSUE. Otherwise stay in IDLE. The FIFO always wins over auto_pending; a pending auto key waits.
  - ISSUE: key_request = 1 for exactly one cycle, then go to GAP. If the key was auto-generated, advance auto_key this cycle.
  - GAP: hold key_value; after GAP_CYCLES cycles go to IDLE.
- Latency: key_request rises 2 cycles after the in_valid handshake when the FSM is in IDLE.
- Request spacing: consecutive key_request pulses are at least GAP_CYCLES+2 cycles apart.
- auto_key advance:
  - mode 1: +1; KEY_LAST wraps to KEY_FIRST.
  - mode 2: -1; KEY_FIRST wraps to KEY_LAST.
  - mode 3: step in the current direction; at KEY_LAST the direction flips to down, at KEY_FIRST it flips to up. The endpoint is not repeated, and direction is updated on the same advance.
  - If KEY_FIRST == KEY_LAST, auto_key is constant in all modes.
- mode 0 with auto_en = 1: ticks still set auto_pending but nothing is issued. On a switch to a nonzero mode, the pending key is issued.
- Mode change takes effect at the next advance; auto_key is never reloaded by a mode change.
- rst mid-GAP or mid-ISSUE: immediate return to reset values. FIFO contents are discarded.

Optional Feature:
- Macro: HID_KEY_RELEASE_EN.
- Defined:
  - After GAP, the FSM enters RELEASE: key_value = 16'h0000, key_request = 1 for one cycle.
  - It then enters a second GAP of GAP_CYCLES before IDLE.
  - Every key produces a press request followed by a release request.
- Undefined: the RELEASE state and second GAP are not generated; a single request is issued per key.

Test Plan (bench parameters unless stated: CLK_HZ=1000, PERIOD_MS=10 → PERIOD_CYC=10, GAP_CYCLES=3, KEY_FIRST=4, KEY_LAST=6, FIFO_DEPTH=4):
- Auto up: auto_en=1, mode=1, no injection → key_request every 10 cycles, key_value 4,5,6,4,5; pulse width 1 cycle.
- Ping-pong: mode=3 → sequence 4,5,6,5,4,5; then mode=2 mid-run after issuing 6 → next keys 5,4,6.
- Injection priority: push 0x1E,0x1F in the cycle auto_pending sets → requests 0x1E, 0x1F, then the auto key. Pulses are 5 cycles apart (GAP_CYCLES+2) and the auto key is not lost.
- FIFO full: push 5 keys back-to-back with the FSM in GAP → in_ready drops after the 4th push, fifo_count=4, 5th not accepted. Same-cycle push and pop while full → count stays at 3 after the pop.
- Reset mid-operation: assert rst during GAP with 2 keys queued → key_request=0, key_value=4, fifo_count=0 asynchronously. After release, the first auto key is 4 at cycle 10.
- HID_KEY_RELEASE_EN defined: single injected 0x04 → pulse with 0x04, pulse with 0x0000 four cycles later, busy low 4 cycles after the second pulse.
